capture_ctrl: RTL and testbench
===============================

# capture_ctrl

Frame-capture controller that sits between the `camera` pixel-stream block and the frame-buffer memory port. It arms on command, waits for the start of a fresh frame, and buffers each valid pixel with its computed linear address in a small FIFO. It drains that FIFO to memory over a req/ack handshake and reports completion, overflow and frame count. It runs entirely in the `PIXCLK` domain.

## Interface
- `DATA_W`, 10, pixel width
- `WIDTH`, 752, pixels per line
- `HEIGHT`, 480, lines per frame
- `LINE_W`, 9, width of `CURRENT_LINE`
- `COL_W`, 10, width of `CURRENT_COLUMN`
- `ADDR_W`, 19, memory address width; must be ≥ clog2(WIDTH*HEIGHT)
- `FIFO_DEPTH`, 8, buffered pixels (power of two, ≥2)

- `PIXCLK`  in  1  sole clock, rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `START`  in  1  arm request, sampled per cycle
- `CONTINUOUS`  in  1  re-arm automatically after each frame
- `ABORT`  in  1  cancel capture
- `PIXEL_VALID`  in  1  from `camera`
- `DATA_IN`  in  DATA_W  pixel from `camera`
- `CURRENT_LINE`  in  LINE_W  from `camera`
- `CURRENT_COLUMN`  in  COL_W  from `camera`
- `MEM_REQ`  out  1  write request
- `MEM_ADDR`  out  ADDR_W  write address
- `MEM_DATA`  out  DATA_W  write data
- `MEM_ACK`  in  1  write accepted this cycle
- `BUSY`  out  1  high in any state but IDLE
- `DONE`  out  1  one-cycle pulse at frame completion
- `OVERFLOW`  out  1  sticky: a pixel was dropped
- `FRAME_COUNT`  out  16  completed frames, wraps at 65535→0

## Operation
- States: IDLE, ARMED, CAPTURE, DRAIN, FLUSH.
- IDLE: `START` → ARMED; `OVERFLOW` cleared on the same edge.
- ARMED: pixels ignored until `PIXEL_VALID` with line 0 and column 0; that pixel is pushed, → CAPTURE. Arming mid-frame therefore skips the remainder of the ongoing frame.
- CAPTURE: each `PIXEL_VALID` pushes {line*WIDTH+col, DATA_IN}. Address arithmetic is done at ADDR_W bits and is unsigned. Pushing pixel (HEIGHT-1, WIDTH-1) → DRAIN.
- CAPTURE also accepts a second (0,0) pixel, meaning a truncated frame: it is pushed and capture continues as a new frame; no DONE is raised.
- DRAIN: further pixels are ignored. When the FIFO is empty and `MEM_REQ` is low, assert `DONE` for one cycle, increment `FRAME_COUNT`, then → ARMED if `CONTINUOUS` else IDLE.
- Push into a full FIFO: the pixel is dropped, `OVERFLOW` is set, and the state machine proceeds unaffected. Because addresses derive from line/column, later pixels keep correct addresses.
- `ABORT` in ARMED/CAPTURE/DRAIN → FLUSH. FLUSH discards all FIFO entries not yet presented. If `MEM_REQ` is high it is held until `MEM_ACK`, then → IDLE. No DONE, no count increment.
- `ABORT` together with `START` in IDLE: ABORT wins and the state stays IDLE. `START` outside IDLE is ignored.

## Timing
- Reset: state IDLE, FIFO empty. All outputs are 0: `MEM_REQ`, `MEM_ADDR`, `MEM_DATA`, `BUSY`, `DONE`, `OVERFLOW`, `FRAME_COUNT`.
- A pixel sampled at edge t is stored at t. When the FIFO was empty and `MEM_REQ` was low, `MEM_REQ` rises after edge t+1 with that entry.
- `MEM_REQ`, `MEM_ADDR` and `MEM_DATA` are registered and stable while `MEM_REQ` is high and `MEM_ACK` is low.
- A transfer completes on an edge with `MEM_REQ`&`MEM_ACK`. The next entry, if any, is presented after that same edge, so `MEM_REQ` stays high. Sustained throughput is 1 write/cycle with `MEM_ACK` tied high.
- Simultaneous push and pop in the same cycle is allowed at any occupancy, including full: a pop frees the slot in the same cycle.
- `DONE` and the `FRAME_COUNT` update occur on the same edge. `BUSY` drops on the edge after the DONE cycle (non-continuous).
- Reset asserted mid-operation: immediate return to reset values with no handshake completion. The memory side must tolerate an abandoned request.

## Structure
- `capture_pkg`: state enum, FIFO entry width constant (ADDR_W+DATA_W), and a function for the linear-address computation.
- Sub-module `capture_fifo`: synchronous FIFO with registered output, count-based full/empty, flush input, and push/pop on the same clock.
- `capture_ctrl` holds the FSM, address generation, output/handshake register and counters.

## Test plan
All scenarios use WIDTH=2, HEIGHT=3 and ACK high unless noted.
- Arm mid-frame: START during an ongoing frame (line 1). Pixels before (0,0) are not written; the next frame's pixels 11,12,21,22,31,32 go to addresses 0–5 in order. DONE pulses once, and FRAME_COUNT=1.
- Backpressure: MEM_ACK low for 5 cycles during CAPTURE with FIFO_DEPTH=8. No drops and OVERFLOW=0; REQ/ADDR/DATA are held stable throughout the stall.
- Overflow: FIFO_DEPTH=2 and MEM_ACK low for the whole frame, then released. Exactly 2 writes occur (addresses 0,1), OVERFLOW=1, DONE pulses, and OVERFLOW clears on the next START.
- Continuous: CONTINUOUS=1 across 3 frames. DONE fires 3 times, FRAME_COUNT=3, and BUSY stays high throughout.
- Abort: ABORT asserted while REQ is pending with ACK low. REQ is held until ACK; the remaining FIFO entries are never written, there is no DONE, and the state returns to IDLE. ABORT+START in IDLE leaves BUSY=0.
- Reset: RST_N pulsed low mid-CAPTURE. All outputs read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : capture_pkg
// Brief    : Shared types and helpers for the frame-capture controller.
// Revision : 1.0
// ============================================================================
package capture_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_DRAIN   = 3'd3,
        S_FLUSH   = 3'd4
    } cap_state_e;

    localparam int ADDR_CALC_W = 32;

    // A FIFO entry is {address, pixel}.
    function automatic int entry_width(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    function automatic logic [ADDR_CALC_W-1:0] linear_addr(
        input logic [ADDR_CALC_W-1:0] line,
        input logic [ADDR_CALC_W-1:0] col,
        input logic [ADDR_CALC_W-1:0] width
    );
        return line * width + col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/capture_fifo.sv
`default_nettype none
// ============================================================================
// Module   : capture_fifo
// Brief    : Synchronous pixel FIFO with count-based flags and flush.
// Revision : 1.0
// ============================================================================
module capture_fifo #(
    parameter int ENTRY_W = 29,
    parameter int DEPTH   = 8,
    parameter int CAP     = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    output logic [ENTRY_W-1:0] rdata_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(CAP));

endmodule
`default_nettype wire

// File: rtl/capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : capture_ctrl
// Brief    : Arms on command, buffers one frame of pixels, writes it to memory.
// Revision : 1.0
// ============================================================================
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int DATA_W     = 10,
    parameter int WIDTH      = 752,
    parameter int HEIGHT     = 480,
    parameter int LINE_W     = 9,
    parameter int COL_W      = 10,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              PIXCLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              CONTINUOUS,
    input  logic              ABORT,
    input  logic              PIXEL_VALID,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic [LINE_W-1:0] CURRENT_LINE,
    input  logic [COL_W-1:0]  CURRENT_COLUMN,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DATA,
    input  logic              MEM_ACK,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVERFLOW,
    output logic [15:0]       FRAME_COUNT
);

    localparam int ENTRY_W = entry_width(ADDR_W, DATA_W);

    cap_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       fcnt_q, fcnt_d;

    logic               fifo_empty;
    logic               fifo_full;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic [ENTRY_W-1:0] fifo_wdata;

    logic              w_origin;
    logic              w_last;
    logic              w_abort;
    logic              w_flush;
    logic              w_push_req;
    logic              w_push_ok;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_pix_addr;

    assign w_pix_addr = ADDR_W'(linear_addr(32'(CURRENT_LINE), 32'(CURRENT_COLUMN), 32'(WIDTH)));
    assign fifo_wdata = {w_pix_addr, DATA_IN};

    assign w_origin = PIXEL_VALID && (CURRENT_LINE == '0) && (CURRENT_COLUMN == '0);
    assign w_last   = (CURRENT_LINE == LINE_W'(HEIGHT - 1)) && (CURRENT_COLUMN == COL_W'(WIDTH - 1));
    assign w_abort  = ABORT && ((state_q == S_ARMED) || (state_q == S_CAPTURE) || (state_q == S_DRAIN));
    assign w_flush  = w_abort || (state_q == S_FLUSH);

    assign w_push_req = !w_abort && (((state_q == S_ARMED) && w_origin) ||
                                     ((state_q == S_CAPTURE) && PIXEL_VALID));

    // The presented entry still occupies a slot until acked, so the FIFO proper
    // holds FIFO_DEPTH-1 entries and a completing ack frees room for a push.
    assign w_pop     = !w_flush && !fifo_empty && (!req_q || MEM_ACK);
    assign w_push_ok = !fifo_full || w_pop;
    assign w_push    = w_push_req && w_push_ok;

    capture_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (FIFO_DEPTH),
        .CAP     (FIFO_DEPTH - 1)
    ) u_fifo (
        .clk     (PIXCLK),
        .rst_n   (RST_N),
        .flush_i (w_flush),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            S_IDLE: begin
                if (START && !ABORT) begin
                    state_d = S_ARMED;
                    ovf_d   = 1'b0;
                end
            end
            S_ARMED: begin
                if (ABORT) begin
                    state_d = S_FLUSH;
                end else if (w_origin) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (ABORT) begin
                    state_d = S_FLUSH;
                end else if (PIXEL_VALID && w_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ABORT) begin
                    state_d = S_FLUSH;
                end else if (fifo_empty && !req_q) begin
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + 16'd1;
                    state_d = CONTINUOUS ? S_ARMED : S_IDLE;
                end
            end
            S_FLUSH: begin
                if (!req_q || MEM_ACK) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (w_push_req && !w_push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        req_d  = req_q;
        addr_d = addr_q;
        data_d = data_q;
        if (w_pop) begin
            req_d  = 1'b1;
            addr_d = fifo_rdata[ENTRY_W-1:DATA_W];
            data_d = fifo_rdata[DATA_W-1:0];
        end else if (req_q && MEM_ACK) begin
            req_d  = 1'b0;
        end
    end

    always_ff @(posedge PIXCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign MEM_REQ     = req_q;
    assign MEM_ADDR    = addr_q;
    assign MEM_DATA    = data_q;
    assign DONE        = done_q;
    assign OVERFLOW    = ovf_q;
    assign FRAME_COUNT = fcnt_q;
    // Held through the DONE cycle so BUSY falls one edge after the pulse.
    assign BUSY        = (state_q != S_IDLE) || done_q;

endmodule
`default_nettype wire

// File: tb/tb_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_ctrl
// Brief    : Scoreboard bench for capture_ctrl on a 2x3 frame.
// Revision : 1.0
// ============================================================================
module tb_capture_ctrl;

    localparam int DW = 10;
    localparam int AW = 19;
    localparam int W  = 2;
    localparam int H  = 3;
    localparam int LW = 9;
    localparam int CW = 10;

    typedef logic [AW+DW-1:0] entry_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, cont, abort, pv;
    logic [DW-1:0] din;
    logic [LW-1:0] line;
    logic [CW-1:0] col;
    logic          ack1, ack2, start2, abort2;

    logic          req1, done1, busy1, ovf1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] data1;
    logic [15:0]   fc1;
    logic          req2, done2, busy2, ovf2;
    logic [AW-1:0] addr2;
    logic [DW-1:0] data2;
    logic [15:0]   fc2;

    int     checks = 0;
    int     errors = 0;
    int     ndone1 = 0;
    int     ndone2 = 0;
    int     busy_drops = 0;
    bit     watch_busy = 1'b0;
    entry_t exp1_q[$];
    entry_t exp2_q[$];

    always #5 clk = ~clk;

    capture_ctrl #(
        .DATA_W(DW), .WIDTH(W), .HEIGHT(H), .LINE_W(LW), .COL_W(CW), .ADDR_W(AW), .FIFO_DEPTH(8)
    ) u_dut (
        .PIXCLK(clk), .RST_N(rst_n), .START(start), .CONTINUOUS(cont), .ABORT(abort),
        .PIXEL_VALID(pv), .DATA_IN(din), .CURRENT_LINE(line), .CURRENT_COLUMN(col),
        .MEM_REQ(req1), .MEM_ADDR(addr1), .MEM_DATA(data1), .MEM_ACK(ack1),
        .BUSY(busy1), .DONE(done1), .OVERFLOW(ovf1), .FRAME_COUNT(fc1)
    );

    capture_ctrl #(
        .DATA_W(DW), .WIDTH(W), .HEIGHT(H), .LINE_W(LW), .COL_W(CW), .ADDR_W(AW), .FIFO_DEPTH(2)
    ) u_dut2 (
        .PIXCLK(clk), .RST_N(rst_n), .START(start2), .CONTINUOUS(1'b0), .ABORT(abort2),
        .PIXEL_VALID(pv), .DATA_IN(din), .CURRENT_LINE(line), .CURRENT_COLUMN(col),
        .MEM_REQ(req2), .MEM_ADDR(addr2), .MEM_DATA(data2), .MEM_ACK(ack2),
        .BUSY(busy2), .DONE(done2), .OVERFLOW(ovf2), .FRAME_COUNT(fc2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Every presented request must match the scoreboard head; an ack retires it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req1) begin
                if (exp1_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut1 write: got addr %0d data %0d expected none", addr1, data1);
                end else begin
                    chk("dut1 write", 32'({addr1, data1}), 32'(exp1_q[0]));
                    if (ack1) exp1_q.delete(0);
                end
            end
            if (req2) begin
                if (exp2_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut2 write: got addr %0d data %0d expected none", addr2, data2);
                end else begin
                    chk("dut2 write", 32'({addr2, data2}), 32'(exp2_q[0]));
                    if (ack2) exp2_q.delete(0);
                end
            end
            if (done1) ndone1++;
            if (done2) ndone2++;
            if (watch_busy && !busy1) busy_drops++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        start = 0; cont = 0; abort = 0; pv = 0; din = '0; line = '0; col = '0;
        ack1 = 1; ack2 = 1; start2 = 0; abort2 = 0;
    endtask

    task automatic do_reset();
        init_inputs();
        rst_n = 0;
        ndone1 = 0;
        ndone2 = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        cyc();
    endtask

    task automatic pix(input int l, input int c, input int sel);
        entry_t e;
        pv   = 1;
        line = LW'(l);
        col  = CW'(c);
        din  = DW'((l + 1) * 10 + c + 1);
        e    = {AW'(l * W + c), din};
        if (sel == 1) exp1_q.push_back(e);
        else if (sel == 2) exp2_q.push_back(e);
        cyc();
        pv = 0;
    endtask

    task automatic wait_done(input int which, input int target, input string name);
        int n = 0;
        while ((((which == 1) ? ndone1 : ndone2) < target) && (n < 200)) begin
            cyc();
            n++;
        end
        cyc();
        cyc();
        chk(name, 32'((which == 1) ? ndone1 : ndone2), 32'(target));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " MEM_REQ"}, 32'(req1), 32'd0);
        chk({tag, " MEM_ADDR"}, 32'(addr1), 32'd0);
        chk({tag, " MEM_DATA"}, 32'(data1), 32'd0);
        chk({tag, " BUSY"}, 32'(busy1), 32'd0);
        chk({tag, " DONE"}, 32'(done1), 32'd0);
        chk({tag, " OVERFLOW"}, 32'(ovf1), 32'd0);
        chk({tag, " FRAME_COUNT"}, 32'(fc1), 32'd0);
    endtask

    initial begin
        init_inputs();
        rst_n = 0;
        #2;
        chk_all_zero("reset");
        do_reset();

        // Arm mid-frame: the partial frame is skipped entirely.
        pix(0, 0, 0); pix(0, 1, 0); pix(1, 0, 0);
        start = 1; cyc(); start = 0;
        pix(1, 1, 0); pix(2, 0, 0); pix(2, 1, 0);
        for (int i = 0; i < W * H; i++) pix(i / W, i % W, 1);
        wait_done(1, 1, "armmid done count");
        chk("armmid frame_count", 32'(fc1), 32'd1);
        chk("armmid busy", 32'(busy1), 32'd0);
        chk("armmid pending", 32'(exp1_q.size()), 32'd0);

        // Backpressure: 5-cycle ack stall mid-frame.
        do_reset();
        start = 1; cyc(); start = 0;
        for (int i = 0; i < W * H; i++) begin
            if (i == 3) ack1 = 0;
            pix(i / W, i % W, 1);
        end
        cyc(); cyc();
        ack1 = 1;
        wait_done(1, 1, "bp done count");
        chk("bp overflow", 32'(ovf1), 32'd0);
        chk("bp frame_count", 32'(fc1), 32'd1);
        chk("bp pending", 32'(exp1_q.size()), 32'd0);

        // Overflow on the depth-2 instance with ack held low.
        do_reset();
        ack2 = 0;
        start2 = 1; cyc(); start2 = 0;
        for (int i = 0; i < W * H; i++) pix(i / W, i % W, (i < 2) ? 2 : 0);
        cyc(); cyc();
        chk("ovf sticky", 32'(ovf2), 32'd1);
        chk("ovf no early done", 32'(ndone2), 32'd0);
        ack2 = 1;
        wait_done(2, 1, "ovf done count");
        chk("ovf still set", 32'(ovf2), 32'd1);
        chk("ovf frame_count", 32'(fc2), 32'd1);
        chk("ovf pending", 32'(exp2_q.size()), 32'd0);
        start2 = 1; cyc(); start2 = 0;
        chk("ovf cleared by start", 32'(ovf2), 32'd0);
        abort2 = 1; cyc(); abort2 = 0; cyc();
        chk("ovf aborted idle", 32'(busy2), 32'd0);

        // Continuous: three frames back to back.
        do_reset();
        cont = 1;
        start = 1; cyc(); start = 0;
        watch_busy = 1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < W * H; i++) pix(i / W, i % W, 1);
            repeat (8) cyc();
        end
        wait_done(1, 3, "cont done count");
        watch_busy = 0;
        chk("cont frame_count", 32'(fc1), 32'd3);
        chk("cont busy drops", 32'(busy_drops), 32'd0);
        chk("cont rearmed busy", 32'(busy1), 32'd1);
        abort = 1; cyc(); abort = 0; cyc();
        chk("cont abort idle", 32'(busy1), 32'd0);
        cont = 0;

        // Abort with a request stalled.
        do_reset();
        start = 1; cyc(); start = 0;
        ack1 = 0;
        pix(0, 0, 1);
        chk("req low at store edge", 32'(req1), 32'd0);
        pix(0, 1, 0);
        chk("req high next edge", 32'(req1), 32'd1);
        pix(1, 0, 0);
        abort = 1; cyc(); abort = 0;
        repeat (3) cyc();
        chk("abort req held", 32'(req1), 32'd1);
        chk("abort busy in flush", 32'(busy1), 32'd1);
        ack1 = 1;
        cyc(); cyc();
        chk("abort req released", 32'(req1), 32'd0);
        chk("abort idle", 32'(busy1), 32'd0);
        chk("abort no done", 32'(ndone1), 32'd0);
        chk("abort frame_count", 32'(fc1), 32'd0);
        repeat (4) cyc();
        chk("abort pending", 32'(exp1_q.size()), 32'd0);
        abort = 1; start = 1; cyc(); abort = 0; start = 0;
        chk("abort+start stays idle", 32'(busy1), 32'd0);

        // Asynchronous reset in the middle of a second frame.
        do_reset();
        start = 1; cyc(); start = 0;
        for (int i = 0; i < W * H; i++) pix(i / W, i % W, 1);
        wait_done(1, 1, "rst first frame done");
        start = 1; cyc(); start = 0;
        pix(0, 0, 1); pix(0, 1, 1); pix(1, 0, 0);
        ack1 = 0;
        chk("rst pre req", 32'(req1), 32'd1);
        chk("rst pre addr", 32'(addr1), 32'd1);
        chk("rst pre frame_count", 32'(fc1), 32'd1);
        #2 rst_n = 0;
        #1;
        chk_all_zero("async reset");
        exp1_q.delete();
        do_reset();

        chk("final dut1 pending", 32'(exp1_q.size()), 32'd0);
        chk("final dut2 pending", 32'(exp2_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
